// File: rtl/forward_hazard_unit.sv
// Operand-forwarding select and load-use stall generator for the ID/EX register-file muxes.
// Latency: selects and stall are combinational from ID sources and the EX/MEM/WB shadow pipeline.
// Backpressure: stall holds PC and IF/ID for one cycle and injects a bubble into EX; flush overrides stall.
// Optional feature: define STALL_COUNT_EN to build the saturating load-use stall counter.
module forward_hazard_unit #(
    parameter int REG_W  = 4,
    parameter int PC_REG = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic [2:0]       id_use,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             flush,
    output logic [1:0]       sel_a,
    output logic [1:0]       sel_b,
    output logic [1:0]       sel_c,
    output logic             stall,
    output logic [31:0]      stall_count
);

    localparam logic [REG_W-1:0] PC_R = REG_W'(PC_REG);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } stage_t;

    stage_t ex_q, mem_q, wb_q;
    stage_t ex_d;
    stage_t id_entry;

    logic [REG_W-1:0] src [3];
    logic [1:0]       sel_v [3];
    logic             hazard;

    // A stage feeds a source only if it really writes that register, the source is in use,
    // and the source is not the PC (which is always read from the register file).
    function automatic logic stage_match(input stage_t s, input logic [REG_W-1:0] r, input logic use_b);
        return s.valid && s.wr_en && (s.dest == r) && (r != PC_R) && use_b;
    endfunction

    assign src[0] = id_rn;
    assign src[1] = id_rm;
    assign src[2] = id_rd;

    assign id_entry = '{valid: 1'b1, wr_en: id_wr_en, dest: id_dest, is_load: id_is_load};

    // Per-source select with EX > MEM > WB > RF priority; a load in EX raises the hazard instead.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel_v[i] = SEL_RF;
            if (stage_match(ex_q, src[i], id_use[i])) begin
                if (ex_q.is_load) begin
                    hazard = 1'b1;
                end else begin
                    sel_v[i] = SEL_EX;
                end
            end else if (stage_match(mem_q, src[i], id_use[i])) begin
                sel_v[i] = SEL_MEM;
            end else if (stage_match(wb_q, src[i], id_use[i])) begin
                sel_v[i] = SEL_WB;
            end
        end
    end

    assign sel_a = sel_v[0];
    assign sel_b = sel_v[1];
    assign sel_c = sel_v[2];
    assign stall = hazard && !flush;

    // A stalled or flushed ID instruction never enters EX; a bubble takes its place.
    always_comb begin
        ex_d = '0;
        if (!stall && !flush) begin
            ex_d = id_entry;
        end
    end

    // Shadow pipeline advances every cycle; only EX can receive a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

`ifdef STALL_COUNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Count stall cycles, holding at all-ones rather than wrapping.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed scoreboard bench for forward_hazard_unit: each vector pushes its hand-computed
// expected outputs; a monitor on the falling edge pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_forward_hazard_unit;

    logic        clk;
    logic        reset_n;
    logic [3:0]  id_rn, id_rm, id_rd, id_dest;
    logic [2:0]  id_use;
    logic        id_wr_en, id_is_load, flush;
    logic [1:0]  sel_a, sel_b, sel_c;
    logic        stall;
    logic [31:0] stall_count;

    forward_hazard_unit #(.REG_W(4), .PC_REG(15)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_rd       (id_rd),
        .id_use      (id_use),
        .id_dest     (id_dest),
        .id_wr_en    (id_wr_en),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .sel_c       (sel_c),
        .stall       (stall),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [1:0]  c;
        logic        st;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   vec_id = 0;
    logic [31:0] stalls_exp = 32'd0;

    // Monitor: outputs are valid every cycle, so compare on each falling edge that has an expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] cnt_req;
            e = exp_q.pop_front();
`ifdef STALL_COUNT_EN
            cnt_req = e.cnt;
`else
            cnt_req = 32'd0;
`endif
            n_vec++;
            if (sel_a !== e.a || sel_b !== e.b || sel_c !== e.c || stall !== e.st || stall_count !== cnt_req) begin
                n_miss++;
                $display("FAIL vec%0d: got a=%b b=%b c=%b stall=%b cnt=%0d, required a=%b b=%b c=%b stall=%b cnt=%0d",
                         e.id, sel_a, sel_b, sel_c, stall, stall_count, e.a, e.b, e.c, e.st, cnt_req);
            end
        end
    end

    // Apply one ID-stage vector just after the rising edge and queue its expected outputs.
    // The expected counter value is the number of stall vectors clocked since the last reset.
    task automatic vec(input logic rst, input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                       input logic [2:0] use_b, input logic [3:0] dest, input logic wr, input logic ld,
                       input logic fl, input logic [1:0] ea, input logic [1:0] eb, input logic [1:0] ec,
                       input logic est);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n    = rst;
        id_rn      = rn;
        id_rm      = rm;
        id_rd      = rd;
        id_use     = use_b;
        id_dest    = dest;
        id_wr_en   = wr;
        id_is_load = ld;
        flush      = fl;
        if (!rst) stalls_exp = 32'd0;
        e.id  = vec_id;
        e.a   = ea;
        e.b   = eb;
        e.c   = ec;
        e.st  = est;
        e.cnt = stalls_exp;
        exp_q.push_back(e);
        if (est) stalls_exp = stalls_exp + 32'd1;
        vec_id++;
    endtask

    initial begin
        reset_n = 1'b0;
        id_rn = '0; id_rm = '0; id_rd = '0; id_use = '0;
        id_dest = '0; id_wr_en = 1'b0; id_is_load = 1'b0; flush = 1'b0;

        //   rst  rn  rm  rd  use     dest wr ld fl   a      b      c    stall
        // power-on reset
        vec(0, 0,  0,  0,  3'b000, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        // ALU forwarding: ADD r3; SUB r5,r3,r4 -> EX; then MEM; then WB
        vec(1, 1,  2,  0,  3'b011, 3,  1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        vec(1, 3,  4,  0,  3'b011, 5,  1, 0, 0, 2'b01, 2'b00, 2'b00, 0);
        vec(1, 3,  0,  0,  3'b001, 0,  0, 0, 0, 2'b10, 2'b00, 2'b00, 0);
        vec(1, 0,  3,  0,  3'b010, 0,  0, 0, 0, 2'b00, 2'b11, 2'b00, 0);
        vec(1, 0,  0,  5,  3'b100, 0,  0, 0, 0, 2'b00, 2'b00, 2'b11, 0);
        vec(1, 0,  0,  0,  3'b000, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        // load-use: LDR r2; ADD r6,r2,r2 stalls once, then forwards from MEM
        vec(1, 1,  0,  0,  3'b001, 2,  1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        vec(1, 2,  2,  0,  3'b011, 6,  1, 0, 0, 2'b00, 2'b00, 2'b00, 1);
        vec(1, 2,  2,  0,  3'b011, 6,  1, 0, 0, 2'b10, 2'b10, 2'b00, 0);
        vec(1, 0,  0,  0,  3'b000, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        // load-use with flush: no stall, the flushed ADD r8 never enters EX
        vec(1, 0,  0,  0,  3'b000, 2,  1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        vec(1, 2,  0,  0,  3'b001, 8,  1, 0, 1, 2'b00, 2'b00, 2'b00, 0);
        vec(1, 8,  2,  0,  3'b011, 0,  0, 0, 0, 2'b00, 2'b10, 2'b00, 0);
        // r7 written in both EX and MEM -> EX wins; r15 in EX never forwards
        vec(1, 0,  0,  0,  3'b000, 7,  1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        vec(1, 0,  0,  0,  3'b000, 7,  1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        vec(1, 7,  0,  0,  3'b001, 15, 1, 0, 0, 2'b01, 2'b00, 2'b00, 0);
        vec(1, 15, 7,  0,  3'b011, 0,  0, 0, 0, 2'b00, 2'b10, 2'b00, 0);
        // r7 in WB but operand unused -> no forward
        vec(1, 7,  0,  0,  3'b000, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        // second and third load-use hazards (source C, then source B)
        vec(1, 0,  0,  0,  3'b000, 9,  1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        vec(1, 0,  0,  9,  3'b100, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
        vec(1, 0,  0,  9,  3'b100, 0,  0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
        vec(1, 0,  0,  0,  3'b000, 10, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        vec(1, 0,  10, 0,  3'b010, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
        vec(1, 0,  10, 0,  3'b010, 0,  0, 0, 0, 2'b00, 2'b10, 2'b00, 0);
        vec(1, 0,  0,  0,  3'b000, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        // fill EX/MEM/WB with writes to r1, r2, r3, then reset mid-run
        vec(1, 0,  0,  0,  3'b000, 1,  1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        vec(1, 0,  0,  0,  3'b000, 2,  1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        vec(1, 0,  0,  0,  3'b000, 3,  1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        vec(0, 3,  2,  1,  3'b111, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        vec(1, 3,  2,  1,  3'b111, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
